ps2_key_decoder: RTL and testbench

Receives PS/2 keyboard frames on the raw PS/2 clock and data pins, then decodes make, break and E0 codes. Produces the held-key code consumed by the game top level as i_key_1 or i_key_2. Consumers compare the key byte every cycle, for example 8'h75 up, 8'h72 down, 8'h5a enter and 8'h76 esc. The output is therefore a level that holds the most recently pressed, still-held key and returns to 8'h00 on its release. One instance sits per keyboard port, between the board pins and the top-level game controller.

---
 rtl/ps2_key_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw pins, frames bytes and
// tracks the most recently pressed, still-held key (with E0 extension).
module ps2_key_decoder #(
  parameter int unsigned FILTER      = 8,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_key,
  output logic       o_ext,
  output logic       o_make,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [7:0] FLT_LAST = 8'(FILTER - 1);

  logic       clk_s1;
  logic       clk_s2;
  logic       dat_s1;
  logic       dat_s2;
  logic       clk_f;
  logic [7:0] flt_cnt;
  logic       strobe;
  logic       samp;

  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  sh;
  logic        par;
  logic [15:0] to_cnt;
  logic        e0_pend;
  logic        f0_pend;

  logic good;
  logic to_hit;
  logic is_e0;
  logic is_f0;
  logic is_ign;
  logic is_brk;
  logic is_mk;

  // Idle PS/2 lines float high, so the synchronizers start there too.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= i_ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= i_ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // A new level is accepted after FILTER consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_f   <= 1'b1;
      flt_cnt <= 8'd0;
      strobe  <= 1'b0;
      samp    <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s2 != clk_f) begin
        if (flt_cnt == FLT_LAST) begin
          clk_f   <= clk_s2;
          flt_cnt <= 8'd0;
          strobe  <= ~clk_s2;
          samp    <= dat_s2;
        end else begin
          flt_cnt <= flt_cnt + 8'd1;
        end
      end else begin
        flt_cnt <= 8'd0;
      end
    end
  end

  assign good   = samp & (^sh ^ par);
  assign to_hit = (state != S_IDLE) && !strobe &&
                  (to_cnt == TIMEOUT_CYC - 16'd1);

  assign is_e0  = (sh == 8'hE0);
  assign is_f0  = (sh == 8'hF0);
  assign is_ign = (sh == 8'h00) || (sh == 8'hAA) ||
                  (sh == 8'hEE) || (sh == 8'hFA) ||
                  (sh == 8'hFC) || (sh == 8'hFF);
  assign is_brk = !is_e0 && !is_f0 && !is_ign && f0_pend;
  assign is_mk  = !is_e0 && !is_f0 && !is_ign && !f0_pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      bit_cnt      <= 3'd0;
      sh           <= 8'd0;
      par          <= 1'b0;
      to_cnt       <= 16'd0;
      e0_pend      <= 1'b0;
      f0_pend      <= 1'b0;
      o_key        <= 8'd0;
      o_ext        <= 1'b0;
      o_make       <= 1'b0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_make       <= 1'b0;
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
      if (strobe) begin
        to_cnt <= 16'd0;
        unique case (1'b1)
          (state == S_IDLE): begin
            if (!samp) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          (state == S_DATA): begin
            sh      <= {samp, sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          (state == S_PARITY): begin
            par   <= samp;
            state <= S_STOP;
          end
          (state == S_STOP): begin
            state <= S_IDLE;
            if (good) begin
              o_byte_valid <= 1'b1;
              o_byte       <= sh;
              unique case (1'b1)
                is_e0: e0_pend <= 1'b1;
                is_f0: f0_pend <= 1'b1;
                is_ign: begin
                  e0_pend <= 1'b0;
                  f0_pend <= 1'b0;
                end
                is_brk: begin
                  // Only releasing the tracked key clears it.
                  if (sh == o_key && e0_pend == o_ext) begin
                    o_key <= 8'd0;
                    o_ext <= 1'b0;
                  end
                  e0_pend <= 1'b0;
                  f0_pend <= 1'b0;
                end
                is_mk: begin
                  o_key   <= sh;
                  o_ext   <= e0_pend;
                  o_make  <= 1'b1;
                  e0_pend <= 1'b0;
                  f0_pend <= 1'b0;
                end
              endcase
            end else begin
              o_err   <= 1'b1;
              e0_pend <= 1'b0;
              f0_pend <= 1'b0;
            end
          end
        endcase
      end else if (to_hit) begin
        o_err   <= 1'b1;
        state   <= S_IDLE;
        to_cnt  <= 16'd0;
        e0_pend <= 1'b0;
        f0_pend <= 1'b0;
      end else if (state != S_IDLE) begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames driven on the raw pins,
// expected key state and pulse counts worked out by hand.
module tb_ps2_key_decoder;

  localparam int          FILT = 8;
  localparam logic [15:0] TOUT = 16'd400;
  localparam int          HALF = 40;
  localparam int          GAP  = 60;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_ps2_clk;
  logic       i_ps2_dat;
  logic [7:0] o_key;
  logic       o_ext;
  logic       o_make;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       o_err;

  int n_cmp;
  int n_bad;
  int n_make;
  int n_bv;
  int n_errp;
  int n_both;
  int s_make;
  int s_bv;
  int s_err;

  ps2_key_decoder #(
    .FILTER      (FILT),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ps2_clk    (i_ps2_clk),
    .i_ps2_dat    (i_ps2_dat),
    .o_key        (o_key),
    .o_ext        (o_ext),
    .o_make       (o_make),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_make)       n_make++;
    if (o_byte_valid) n_bv++;
    if (o_err)        n_errp++;
    if (o_err && o_byte_valid) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic snap();
    s_make = n_make;
    s_bv   = n_bv;
    s_err  = n_errp;
  endtask

  // First nbits of a frame: start, data LSB first, odd parity, stop.
  task automatic send_bits(input logic [7:0] b, input logic bad_par,
                           input logic bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      i_ps2_dat = f[i];
      cyc(HALF);
      i_ps2_clk = 1'b0;
      cyc(HALF);
      i_ps2_clk = 1'b1;
    end
    i_ps2_dat = 1'b1;
    cyc(GAP);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b0, 11);
  endtask

  initial begin
    n_cmp = 0;  n_bad = 0;
    n_make = 0; n_bv = 0; n_errp = 0; n_both = 0;
    i_rst_n   = 1'b0;
    i_ps2_clk = 1'b1;
    i_ps2_dat = 1'b1;
    cyc(4);
    chk("rst_key", {24'd0, o_key}, 32'h00);
    chk("rst_byte", {24'd0, o_byte}, 32'h00);
    chk("rst_pulses", {29'd0, o_make, o_byte_valid, o_err}, 32'd0);
    i_rst_n = 1'b1;
    cyc(10);

    // Enter make/break
    snap();
    send(8'h5A);
    chk("enter_key", {24'd0, o_key}, 32'h5A);
    chk("enter_make", n_make - s_make, 32'd1);
    send(8'hF0);
    chk("enter_f0_key", {24'd0, o_key}, 32'h5A);
    send(8'h5A);
    chk("enter_brk_key", {24'd0, o_key}, 32'h00);
    chk("enter_byte", {24'd0, o_byte}, 32'h5A);
    chk("enter_bv", n_bv - s_bv, 32'd3);
    chk("enter_err", n_errp - s_err, 32'd0);
    chk("enter_makes", n_make - s_make, 32'd1);

    // Extended up arrow
    send(8'hE0);
    send(8'h75);
    chk("up_key", {24'd0, o_key}, 32'h75);
    chk("up_ext", {31'd0, o_ext}, 32'd1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("up_brk_key", {24'd0, o_key}, 32'h00);
    chk("up_brk_ext", {31'd0, o_ext}, 32'd0);

    // Overlapping keys
    send(8'h72);
    send(8'h76);
    chk("ovl_key", {24'd0, o_key}, 32'h76);
    send(8'hF0);
    send(8'h72);
    chk("ovl_rel_key", {24'd0, o_key}, 32'h76);

    // 5A has even weight, so parity 0 is the error case.
    snap();
    send_bits(8'h5A, 1'b1, 1'b0, 11);
    chk("par_err", n_errp - s_err, 32'd1);
    chk("par_bv", n_bv - s_bv, 32'd0);
    chk("par_key", {24'd0, o_key}, 32'h76);
    send(8'hF0);
    send_bits(8'h33, 1'b1, 1'b0, 11);
    snap();
    send(8'h5A);
    chk("par_f0clr_key", {24'd0, o_key}, 32'h5A);
    chk("par_f0clr_make", n_make - s_make, 32'd1);

    // Stop-bit error
    snap();
    send_bits(8'h29, 1'b0, 1'b1, 11);
    chk("stop_err", n_errp - s_err, 32'd1);
    chk("stop_key", {24'd0, o_key}, 32'h5A);

    // Timeout mid-frame
    snap();
    send_bits(8'h72, 1'b0, 1'b0, 4);
    cyc(int'(TOUT) + 10);
    chk("to_err", n_errp - s_err, 32'd1);
    chk("to_bv", n_bv - s_bv, 32'd0);
    send(8'h72);
    chk("to_next_key", {24'd0, o_key}, 32'h72);

    // Sub-filter glitch with data low must not start a frame
    snap();
    i_ps2_dat = 1'b0;
    i_ps2_clk = 1'b0;
    cyc(FILT - 1);
    i_ps2_clk = 1'b1;
    cyc(GAP);
    i_ps2_dat = 1'b1;
    chk("gl_key", {24'd0, o_key}, 32'h72);
    chk("gl_pulses", (n_bv - s_bv) + (n_errp - s_err), 32'd0);
    send(8'h75);
    chk("gl_next_key", {24'd0, o_key}, 32'h75);
    chk("gl_next_ext", {31'd0, o_ext}, 32'd0);

    // Reset pulse after data bit 5
    send_bits(8'h5A, 1'b0, 1'b0, 6);
    i_rst_n = 1'b0;
    cyc(1);
    i_rst_n = 1'b1;
    chk("rst2_key", {24'd0, o_key}, 32'h00);
    chk("rst2_byte", {24'd0, o_byte}, 32'h00);
    chk("rst2_ext", {31'd0, o_ext}, 32'd0);
    cyc(GAP);
    send(8'h6B);
    chk("rst2_next_key", {24'd0, o_key}, 32'h6B);
    chk("rst2_next_byte", {24'd0, o_byte}, 32'h6B);

    chk("err_bv_excl", n_both, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
